// File: rtl/mcp3_afu_top_if.sv
// TLX <-> AFU signal bundle. Master is the TLX side, slave is the AFU.
interface mcp3_afu_top_if;
    // AFU -> TLX command path
    logic         afu_tlx_cmd_valid;
    logic [7:0]   afu_tlx_cmd_opcode;
    logic [11:0]  afu_tlx_cmd_actag;
    logic [3:0]   afu_tlx_cmd_stream_id;
    logic [67:0]  afu_tlx_cmd_ea_or_obj;
    logic [15:0]  afu_tlx_cmd_afutag;
    logic [1:0]   afu_tlx_cmd_dl;
    logic [2:0]   afu_tlx_cmd_pl;
    logic         afu_tlx_cmd_os;
    logic [63:0]  afu_tlx_cmd_be;
    logic [3:0]   afu_tlx_cmd_flag;
    logic         afu_tlx_cmd_endian;
    logic [15:0]  afu_tlx_cmd_bdf;
    logic [19:0]  afu_tlx_cmd_pasid;
    logic [5:0]   afu_tlx_cmd_pg_size;
    logic         afu_tlx_cdata_valid;
    logic         afu_tlx_cdata_bdi;
    logic [511:0] afu_tlx_cdata_bus;
    // TLX -> AFU command credits
    logic         tlx_afu_cmd_credit;
    logic         tlx_afu_cmd_data_credit;
    logic [2:0]   tlx_afu_cmd_resp_initial_credit;
    logic [4:0]   tlx_afu_data_initial_credit;
    // TLX -> AFU responses
    logic         tlx_afu_resp_valid;
    logic [7:0]   tlx_afu_resp_opcode;
    logic [15:0]  tlx_afu_resp_afutag;
    logic [3:0]   tlx_afu_resp_code;
    logic [1:0]   tlx_afu_resp_dl;
    logic [1:0]   tlx_afu_resp_dp;
    logic [5:0]   tlx_afu_resp_pg_size;
    logic [17:0]  tlx_afu_resp_addr_tag;
    logic         tlx_afu_resp_data_valid;
    logic         tlx_afu_resp_data_bdi;
    logic [511:0] tlx_afu_resp_data_bus;
    logic         afu_tlx_resp_rd_req;
    logic [2:0]   afu_tlx_resp_rd_cnt;
    logic         afu_tlx_resp_credit;
    logic [6:0]   afu_tlx_resp_initial_credit;
    // Host commands
    logic         tlx_afu_ready;
    logic         tlx_afu_cmd_valid;
    logic [7:0]   tlx_afu_cmd_opcode;
    logic [15:0]  tlx_afu_cmd_capptag;
    logic [1:0]   tlx_afu_cmd_dl;
    logic [2:0]   tlx_afu_cmd_pl;
    logic [63:0]  tlx_afu_cmd_be;
    logic         tlx_afu_cmd_end;
    logic         tlx_afu_cmd_t;
    logic [63:0]  tlx_afu_cmd_pa;
    logic [3:0]   tlx_afu_cmd_flag;
    logic         tlx_afu_cmd_os;
    logic         tlx_afu_cmd_data_valid;
    logic         tlx_afu_cmd_data_bdi;
    logic [511:0] tlx_afu_cmd_data_bus;
    logic         afu_tlx_cmd_rd_req;
    logic [2:0]   afu_tlx_cmd_rd_cnt;
    logic         afu_tlx_cmd_credit;
    logic [6:0]   afu_tlx_cmd_initial_credit;
    // Response transmit
    logic         afu_tlx_resp_valid;
    logic [7:0]   afu_tlx_resp_opcode;
    logic [1:0]   afu_tlx_resp_dl;
    logic [15:0]  afu_tlx_resp_capptag;
    logic [1:0]   afu_tlx_resp_dp;
    logic [3:0]   afu_tlx_resp_code;
    logic         afu_tlx_rdata_valid;
    logic         afu_tlx_rdata_bdi;
    logic [511:0] afu_tlx_rdata_bus;
    logic         tlx_afu_resp_credit;
    logic         tlx_afu_resp_data_credit;
    // Config
    logic         afu_cfg_in_rcv_tmpl_capability_0, afu_cfg_in_rcv_tmpl_capability_1;
    logic         afu_cfg_in_rcv_tmpl_capability_2, afu_cfg_in_rcv_tmpl_capability_3;
    logic [3:0]   afu_cfg_in_rcv_rate_capability_0, afu_cfg_in_rcv_rate_capability_1;
    logic [3:0]   afu_cfg_in_rcv_rate_capability_2, afu_cfg_in_rcv_rate_capability_3;
    logic         afu_cfg_xmit_tmpl_config_0, afu_cfg_xmit_tmpl_config_1;
    logic         afu_cfg_xmit_tmpl_config_2, afu_cfg_xmit_tmpl_config_3;
    logic [3:0]   afu_cfg_xmit_rate_config_0, afu_cfg_xmit_rate_config_1;
    logic [3:0]   afu_cfg_xmit_rate_config_2, afu_cfg_xmit_rate_config_3;

    modport slave (
        output afu_tlx_cmd_valid, afu_tlx_cmd_opcode, afu_tlx_cmd_actag, afu_tlx_cmd_stream_id,
               afu_tlx_cmd_ea_or_obj, afu_tlx_cmd_afutag, afu_tlx_cmd_dl, afu_tlx_cmd_pl,
               afu_tlx_cmd_os, afu_tlx_cmd_be, afu_tlx_cmd_flag, afu_tlx_cmd_endian,
               afu_tlx_cmd_bdf, afu_tlx_cmd_pasid, afu_tlx_cmd_pg_size,
               afu_tlx_cdata_valid, afu_tlx_cdata_bdi, afu_tlx_cdata_bus,
               afu_tlx_resp_rd_req, afu_tlx_resp_rd_cnt, afu_tlx_resp_credit,
               afu_tlx_resp_initial_credit, afu_tlx_cmd_rd_req, afu_tlx_cmd_rd_cnt,
               afu_tlx_cmd_credit, afu_tlx_cmd_initial_credit,
               afu_tlx_resp_valid, afu_tlx_resp_opcode, afu_tlx_resp_dl, afu_tlx_resp_capptag,
               afu_tlx_resp_dp, afu_tlx_resp_code, afu_tlx_rdata_valid, afu_tlx_rdata_bdi,
               afu_tlx_rdata_bus,
               afu_cfg_xmit_tmpl_config_0, afu_cfg_xmit_tmpl_config_1,
               afu_cfg_xmit_tmpl_config_2, afu_cfg_xmit_tmpl_config_3,
               afu_cfg_xmit_rate_config_0, afu_cfg_xmit_rate_config_1,
               afu_cfg_xmit_rate_config_2, afu_cfg_xmit_rate_config_3,
        input  tlx_afu_cmd_credit, tlx_afu_cmd_data_credit, tlx_afu_cmd_resp_initial_credit,
               tlx_afu_data_initial_credit, tlx_afu_resp_valid, tlx_afu_resp_opcode,
               tlx_afu_resp_afutag, tlx_afu_resp_code, tlx_afu_resp_dl, tlx_afu_resp_dp,
               tlx_afu_resp_pg_size, tlx_afu_resp_addr_tag, tlx_afu_resp_data_valid,
               tlx_afu_resp_data_bdi, tlx_afu_resp_data_bus,
               tlx_afu_ready, tlx_afu_cmd_valid, tlx_afu_cmd_opcode, tlx_afu_cmd_capptag,
               tlx_afu_cmd_dl, tlx_afu_cmd_pl, tlx_afu_cmd_be, tlx_afu_cmd_end, tlx_afu_cmd_t,
               tlx_afu_cmd_pa, tlx_afu_cmd_flag, tlx_afu_cmd_os, tlx_afu_cmd_data_valid,
               tlx_afu_cmd_data_bdi, tlx_afu_cmd_data_bus,
               tlx_afu_resp_credit, tlx_afu_resp_data_credit,
               afu_cfg_in_rcv_tmpl_capability_0, afu_cfg_in_rcv_tmpl_capability_1,
               afu_cfg_in_rcv_tmpl_capability_2, afu_cfg_in_rcv_tmpl_capability_3,
               afu_cfg_in_rcv_rate_capability_0, afu_cfg_in_rcv_rate_capability_1,
               afu_cfg_in_rcv_rate_capability_2, afu_cfg_in_rcv_rate_capability_3
    );

    modport master (
        input  afu_tlx_cmd_valid, afu_tlx_cmd_opcode, afu_tlx_cmd_actag, afu_tlx_cmd_stream_id,
               afu_tlx_cmd_ea_or_obj, afu_tlx_cmd_afutag, afu_tlx_cmd_dl, afu_tlx_cmd_pl,
               afu_tlx_cmd_os, afu_tlx_cmd_be, afu_tlx_cmd_flag, afu_tlx_cmd_endian,
               afu_tlx_cmd_bdf, afu_tlx_cmd_pasid, afu_tlx_cmd_pg_size,
               afu_tlx_cdata_valid, afu_tlx_cdata_bdi, afu_tlx_cdata_bus,
               afu_tlx_resp_rd_req, afu_tlx_resp_rd_cnt, afu_tlx_resp_credit,
               afu_tlx_resp_initial_credit, afu_tlx_cmd_rd_req, afu_tlx_cmd_rd_cnt,
               afu_tlx_cmd_credit, afu_tlx_cmd_initial_credit,
               afu_tlx_resp_valid, afu_tlx_resp_opcode, afu_tlx_resp_dl, afu_tlx_resp_capptag,
               afu_tlx_resp_dp, afu_tlx_resp_code, afu_tlx_rdata_valid, afu_tlx_rdata_bdi,
               afu_tlx_rdata_bus,
               afu_cfg_xmit_tmpl_config_0, afu_cfg_xmit_tmpl_config_1,
               afu_cfg_xmit_tmpl_config_2, afu_cfg_xmit_tmpl_config_3,
               afu_cfg_xmit_rate_config_0, afu_cfg_xmit_rate_config_1,
               afu_cfg_xmit_rate_config_2, afu_cfg_xmit_rate_config_3,
        output tlx_afu_cmd_credit, tlx_afu_cmd_data_credit, tlx_afu_cmd_resp_initial_credit,
               tlx_afu_data_initial_credit, tlx_afu_resp_valid, tlx_afu_resp_opcode,
               tlx_afu_resp_afutag, tlx_afu_resp_code, tlx_afu_resp_dl, tlx_afu_resp_dp,
               tlx_afu_resp_pg_size, tlx_afu_resp_addr_tag, tlx_afu_resp_data_valid,
               tlx_afu_resp_data_bdi, tlx_afu_resp_data_bus,
               tlx_afu_ready, tlx_afu_cmd_valid, tlx_afu_cmd_opcode, tlx_afu_cmd_capptag,
               tlx_afu_cmd_dl, tlx_afu_cmd_pl, tlx_afu_cmd_be, tlx_afu_cmd_end, tlx_afu_cmd_t,
               tlx_afu_cmd_pa, tlx_afu_cmd_flag, tlx_afu_cmd_os, tlx_afu_cmd_data_valid,
               tlx_afu_cmd_data_bdi, tlx_afu_cmd_data_bus,
               tlx_afu_resp_credit, tlx_afu_resp_data_credit,
               afu_cfg_in_rcv_tmpl_capability_0, afu_cfg_in_rcv_tmpl_capability_1,
               afu_cfg_in_rcv_tmpl_capability_2, afu_cfg_in_rcv_tmpl_capability_3,
               afu_cfg_in_rcv_rate_capability_0, afu_cfg_in_rcv_rate_capability_1,
               afu_cfg_in_rcv_rate_capability_2, afu_cfg_in_rcv_rate_capability_3
    );
endinterface

// File: rtl/mcp3_afu_top.sv
// MMIO-style AFU: serves host reads/writes to a 16x64 register file over TLX,
// never originates AFU commands.
module mcp3_afu_top (
    input logic         clock_afu,
    input logic         clock_tlx,
    input logic         reset,
    mcp3_afu_top_if.slave tlx
);
    localparam logic [63:0] ID_VALUE = 64'h0000_0000_4D43_5033;

    typedef enum logic [1:0] {S_IDLE, S_DREQ, S_DWAIT, S_RESP} state_t;

    state_t       r_state, w_next;
    logic [7:0]   r_op;
    logic [15:0]  r_tag;
    logic [2:0]   r_pl;
    logic [3:0]   r_idx;
    logic [63:0]  r_regs [16];
    logic [3:0]   r_resp_cnt, r_data_cnt;
    logic         r_resp_credit;

    logic         w_accept, w_in_wr, w_is_wr, w_valid, w_rd_ok, w_fire, w_wr_en;
    logic [63:0]  w_rd_val, w_wr_lane;
    logic         w_unused;

    assign w_accept  = (r_state == S_IDLE) && tlx.tlx_afu_ready && tlx.tlx_afu_cmd_valid;
    assign w_in_wr   = (tlx.tlx_afu_cmd_opcode == 8'h86) || (tlx.tlx_afu_cmd_opcode == 8'h81);
    assign w_is_wr   = (r_op == 8'h86) || (r_op == 8'h81);
    assign w_valid   = ((r_op == 8'h28) || (r_op == 8'h86)) && (r_pl == 3'b011);
    assign w_rd_ok   = w_valid && !w_is_wr;
    // Only responses that carry read data need a data credit.
    assign w_fire    = (r_state == S_RESP) && (r_resp_cnt != 4'd0) &&
                       (!w_rd_ok || (r_data_cnt != 4'd0));
    assign w_rd_val  = (r_idx == 4'd0) ? ID_VALUE : r_regs[r_idx];
    assign w_wr_lane = tlx.tlx_afu_cmd_data_bus[{r_idx[2:0], 6'd0} +: 64];
    assign w_wr_en   = (r_state == S_DWAIT) && tlx.tlx_afu_cmd_data_valid &&
                       w_valid && w_is_wr && (r_idx != 4'd0);

    always_ff @(posedge clock_afu) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_tag   <= '0;
            r_pl    <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= tlx.tlx_afu_cmd_opcode;
                r_tag <= tlx.tlx_afu_cmd_capptag;
                r_pl  <= tlx.tlx_afu_cmd_pl;
                r_idx <= tlx.tlx_afu_cmd_pa[6:3];
            end
        end
    end

    always_ff @(posedge clock_afu) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[r_idx] <= w_wr_lane;
        end
    end

    function automatic logic [3:0] f_credit(input logic [3:0] cnt, input logic inc, input logic dec);
        if (inc && !dec && cnt != 4'd15) return cnt + 4'd1;
        if (dec && !inc)                 return cnt - 4'd1;
        return cnt;
    endfunction

    always_ff @(posedge clock_afu) begin
        if (reset) begin
            r_resp_cnt    <= 4'd1;
            r_data_cnt    <= 4'd1;
            r_resp_credit <= 1'b0;
        end else begin
            r_resp_cnt    <= f_credit(r_resp_cnt, tlx.tlx_afu_resp_credit, w_fire);
            r_data_cnt    <= f_credit(r_data_cnt, tlx.tlx_afu_resp_data_credit, w_fire && w_rd_ok);
            r_resp_credit <= tlx.tlx_afu_resp_valid;
        end
    end

    always_comb begin
        w_next                   = r_state;
        tlx.afu_tlx_cmd_rd_req   = 1'b0;
        tlx.afu_tlx_cmd_rd_cnt   = 3'b000;
        tlx.afu_tlx_resp_valid   = 1'b0;
        tlx.afu_tlx_cmd_credit   = 1'b0;
        tlx.afu_tlx_resp_opcode  = 8'h00;
        tlx.afu_tlx_resp_code    = 4'h0;
        tlx.afu_tlx_resp_dl      = 2'b00;
        tlx.afu_tlx_resp_dp      = 2'b00;
        tlx.afu_tlx_resp_capptag = 16'h0000;
        tlx.afu_tlx_rdata_valid  = 1'b0;
        tlx.afu_tlx_rdata_bus    = '0;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_in_wr ? S_DREQ : S_RESP;
            S_DREQ: begin
                tlx.afu_tlx_cmd_rd_req = 1'b1;
                tlx.afu_tlx_cmd_rd_cnt = 3'b001;
                w_next = S_DWAIT;
            end
            S_DWAIT: if (tlx.tlx_afu_cmd_data_valid) w_next = S_RESP;
            S_RESP: begin
                if (w_fire) begin
                    w_next                   = S_IDLE;
                    tlx.afu_tlx_resp_valid   = 1'b1;
                    tlx.afu_tlx_cmd_credit   = 1'b1;
                    tlx.afu_tlx_resp_dl      = 2'b01;
                    tlx.afu_tlx_resp_capptag = r_tag;
                    if (w_is_wr) begin
                        tlx.afu_tlx_resp_opcode = w_valid ? 8'h04 : 8'h05;
                        tlx.afu_tlx_resp_code   = w_valid ? 4'h0 : 4'hE;
                    end else begin
                        tlx.afu_tlx_resp_opcode = w_valid ? 8'h01 : 8'h02;
                        tlx.afu_tlx_resp_code   = w_valid ? 4'h0 : 4'hE;
                    end
                    if (w_rd_ok) begin
                        tlx.afu_tlx_rdata_valid = 1'b1;
                        tlx.afu_tlx_rdata_bus   = 512'(w_rd_val) << {r_idx[2:0], 6'd0};
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign tlx.afu_tlx_cmd_valid           = 1'b0;
    assign tlx.afu_tlx_cmd_opcode          = '0;
    assign tlx.afu_tlx_cmd_actag           = '0;
    assign tlx.afu_tlx_cmd_stream_id       = '0;
    assign tlx.afu_tlx_cmd_ea_or_obj       = '0;
    assign tlx.afu_tlx_cmd_afutag          = '0;
    assign tlx.afu_tlx_cmd_dl              = '0;
    assign tlx.afu_tlx_cmd_pl              = '0;
    assign tlx.afu_tlx_cmd_os              = 1'b0;
    assign tlx.afu_tlx_cmd_be              = '0;
    assign tlx.afu_tlx_cmd_flag            = '0;
    assign tlx.afu_tlx_cmd_endian          = 1'b0;
    assign tlx.afu_tlx_cmd_bdf             = '0;
    assign tlx.afu_tlx_cmd_pasid           = '0;
    assign tlx.afu_tlx_cmd_pg_size         = '0;
    assign tlx.afu_tlx_cdata_valid         = 1'b0;
    assign tlx.afu_tlx_cdata_bdi           = 1'b0;
    assign tlx.afu_tlx_cdata_bus           = '0;
    assign tlx.afu_tlx_resp_rd_req         = 1'b0;
    assign tlx.afu_tlx_resp_rd_cnt         = 3'b000;
    assign tlx.afu_tlx_resp_credit         = r_resp_credit;
    assign tlx.afu_tlx_resp_initial_credit = 7'd1;
    assign tlx.afu_tlx_cmd_initial_credit  = 7'd1;
    assign tlx.afu_tlx_rdata_bdi           = 1'b0;
    assign tlx.afu_cfg_xmit_tmpl_config_0  = 1'b1;
    assign tlx.afu_cfg_xmit_tmpl_config_1  = 1'b0;
    assign tlx.afu_cfg_xmit_tmpl_config_2  = 1'b0;
    assign tlx.afu_cfg_xmit_tmpl_config_3  = 1'b0;
    assign tlx.afu_cfg_xmit_rate_config_0  = 4'h0;
    assign tlx.afu_cfg_xmit_rate_config_1  = 4'h0;
    assign tlx.afu_cfg_xmit_rate_config_2  = 4'h0;
    assign tlx.afu_cfg_xmit_rate_config_3  = 4'h0;

    // Inputs the block has no use for, collected so they are visibly consumed.
    assign w_unused = ^{clock_tlx, tlx.tlx_afu_cmd_credit, tlx.tlx_afu_cmd_data_credit,
                        tlx.tlx_afu_cmd_resp_initial_credit, tlx.tlx_afu_data_initial_credit,
                        tlx.tlx_afu_resp_opcode, tlx.tlx_afu_resp_afutag, tlx.tlx_afu_resp_code,
                        tlx.tlx_afu_resp_dl, tlx.tlx_afu_resp_dp, tlx.tlx_afu_resp_pg_size,
                        tlx.tlx_afu_resp_addr_tag, tlx.tlx_afu_resp_data_valid,
                        tlx.tlx_afu_resp_data_bdi, tlx.tlx_afu_resp_data_bus,
                        tlx.tlx_afu_cmd_dl, tlx.tlx_afu_cmd_be, tlx.tlx_afu_cmd_end,
                        tlx.tlx_afu_cmd_t, tlx.tlx_afu_cmd_pa[63:7], tlx.tlx_afu_cmd_pa[2:0],
                        tlx.tlx_afu_cmd_flag, tlx.tlx_afu_cmd_os, tlx.tlx_afu_cmd_data_bdi,
                        tlx.afu_cfg_in_rcv_tmpl_capability_0, tlx.afu_cfg_in_rcv_tmpl_capability_1,
                        tlx.afu_cfg_in_rcv_tmpl_capability_2, tlx.afu_cfg_in_rcv_tmpl_capability_3,
                        tlx.afu_cfg_in_rcv_rate_capability_0, tlx.afu_cfg_in_rcv_rate_capability_1,
                        tlx.afu_cfg_in_rcv_rate_capability_2, tlx.afu_cfg_in_rcv_rate_capability_3};
endmodule

// File: tb/tb_mcp3_afu_top.sv
// Scoreboard bench for mcp3_afu_top: random host MMIO traffic against a register-array model.
module tb_mcp3_afu_top;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcp3_afu_top_if ifc();

    mcp3_afu_top dut (
        .clock_afu (clk),
        .clock_tlx (clk),
        .reset     (reset),
        .tlx       (ifc)
    );

    localparam logic [63:0] ID_VALUE = 64'h0000_0000_4D43_5033;

    typedef struct {
        logic [7:0]   op;
        logic [15:0]  tag;
        logic [3:0]   code;
        logic         rv;
        logic [511:0] bus;
    } exp_t;

    exp_t        q[$];
    logic [63:0] m_regs [16];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_resp = 0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Response monitor: every response cycle pops one expectation.
    always @(negedge clk) begin
        if (!reset) begin
            check("cmd_credit_with_resp", {511'b0, ifc.afu_tlx_cmd_credit}, {511'b0, ifc.afu_tlx_resp_valid});
            if (ifc.afu_tlx_resp_valid) begin
                n_resp++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_resp: got opcode %0h, expected no response",
                             ifc.afu_tlx_resp_opcode);
                end else begin
                    mon_e = q.pop_front();
                    check("resp_opcode", {504'b0, ifc.afu_tlx_resp_opcode}, {504'b0, mon_e.op});
                    check("resp_capptag", {496'b0, ifc.afu_tlx_resp_capptag}, {496'b0, mon_e.tag});
                    check("resp_code", {508'b0, ifc.afu_tlx_resp_code}, {508'b0, mon_e.code});
                    check("resp_dl", {510'b0, ifc.afu_tlx_resp_dl}, 512'd1);
                    check("resp_dp", {510'b0, ifc.afu_tlx_resp_dp}, 512'd0);
                    check("rdata_valid", {511'b0, ifc.afu_tlx_rdata_valid}, {511'b0, mon_e.rv});
                    if (mon_e.rv) check("rdata_bus", ifc.afu_tlx_rdata_bus, mon_e.bus);
                end
            end else begin
                check("rdata_valid_idle", {511'b0, ifc.afu_tlx_rdata_valid}, 512'd0);
            end
        end
    end

    task automatic check_consts();
        check("cmd_out_zero", {286'b0, ifc.afu_tlx_cmd_valid, ifc.afu_tlx_cmd_opcode, ifc.afu_tlx_cmd_actag,
              ifc.afu_tlx_cmd_stream_id, ifc.afu_tlx_cmd_ea_or_obj, ifc.afu_tlx_cmd_afutag,
              ifc.afu_tlx_cmd_dl, ifc.afu_tlx_cmd_pl, ifc.afu_tlx_cmd_os, ifc.afu_tlx_cmd_be,
              ifc.afu_tlx_cmd_flag, ifc.afu_tlx_cmd_endian, ifc.afu_tlx_cmd_bdf,
              ifc.afu_tlx_cmd_pasid, ifc.afu_tlx_cmd_pg_size}, '0);
        check("cdata_ctl_zero", {510'b0, ifc.afu_tlx_cdata_valid, ifc.afu_tlx_cdata_bdi}, '0);
        check("cdata_bus_zero", ifc.afu_tlx_cdata_bus, '0);
        check("cmd_init_credit", {505'b0, ifc.afu_tlx_cmd_initial_credit}, 512'd1);
        check("resp_init_credit", {505'b0, ifc.afu_tlx_resp_initial_credit}, 512'd1);
        check("resp_rd_req_cnt", {508'b0, ifc.afu_tlx_resp_rd_req, ifc.afu_tlx_resp_rd_cnt}, '0);
        check("tmpl_config", {508'b0, ifc.afu_cfg_xmit_tmpl_config_3, ifc.afu_cfg_xmit_tmpl_config_2,
              ifc.afu_cfg_xmit_tmpl_config_1, ifc.afu_cfg_xmit_tmpl_config_0}, 512'd1);
        check("rate_config", {496'b0, ifc.afu_cfg_xmit_rate_config_3, ifc.afu_cfg_xmit_rate_config_2,
              ifc.afu_cfg_xmit_rate_config_1, ifc.afu_cfg_xmit_rate_config_0}, '0);
        check("rdata_bdi", {511'b0, ifc.afu_tlx_rdata_bdi}, '0);
    endtask

    function automatic logic [63:0] m_read(input logic [3:0] idx);
        return (idx == 4'd0) ? ID_VALUE : m_regs[idx];
    endfunction

    // Issues one host command (and its data beat for write-class opcodes).
    task automatic issue(input logic [7:0] op, input logic [2:0] pl, input logic [63:0] pa,
                         input logic [63:0] wdata, output logic rv);
        exp_t e;
        logic is_wr, valid, got;
        logic [3:0] idx;
        logic [511:0] dbus;
        idx   = pa[6:3];
        is_wr = (op == 8'h86) || (op == 8'h81);
        valid = ((op == 8'h28) || (op == 8'h86)) && (pl == 3'd3);
        e.tag = 16'($urandom);
        e.rv  = 1'b0;
        e.bus = '0;
        if (is_wr) begin
            e.op   = valid ? 8'h04 : 8'h05;
            e.code = valid ? 4'h0 : 4'hE;
            if (valid && idx != 4'd0) m_regs[idx] = wdata;
        end else begin
            e.op   = valid ? 8'h01 : 8'h02;
            e.code = valid ? 4'h0 : 4'hE;
            if (valid) begin
                e.rv  = 1'b1;
                e.bus = 512'(m_read(idx)) << (64 * int'(idx[2:0]));
            end
        end
        rv = e.rv;
        q.push_back(e);
        @(posedge clk); #1;
        ifc.tlx_afu_cmd_valid   = 1'b1;
        ifc.tlx_afu_cmd_opcode  = op;
        ifc.tlx_afu_cmd_capptag = e.tag;
        ifc.tlx_afu_cmd_pl      = pl;
        ifc.tlx_afu_cmd_pa      = pa;
        ifc.tlx_afu_cmd_be      = {$urandom, $urandom};
        @(posedge clk); #1;
        ifc.tlx_afu_cmd_valid   = 1'b0;
        ifc.tlx_afu_cmd_opcode  = 8'($urandom);
        ifc.tlx_afu_cmd_pa      = {$urandom, $urandom};
        if (is_wr) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (ifc.afu_tlx_cmd_rd_req) begin
                    got = 1'b1;
                    check("cmd_rd_cnt", {509'b0, ifc.afu_tlx_cmd_rd_cnt}, 512'd1);
                end
            end
            check("cmd_rd_req_seen", {511'b0, got}, 512'd1);
            dbus = rand512();
            dbus[64*int'(idx[2:0]) +: 64] = wdata;
            @(posedge clk); #1;
            ifc.tlx_afu_cmd_data_valid = 1'b1;
            ifc.tlx_afu_cmd_data_bus   = dbus;
            @(negedge clk);
            check("cmd_rd_req_one_cycle", {511'b0, ifc.afu_tlx_cmd_rd_req}, 512'd0);
            @(posedge clk); #1;
            ifc.tlx_afu_cmd_data_valid = 1'b0;
            ifc.tlx_afu_cmd_data_bus   = rand512();
        end
    endtask

    task automatic pulse_credits(input logic r, input logic d);
        @(posedge clk); #1;
        ifc.tlx_afu_resp_credit      = r;
        ifc.tlx_afu_resp_data_credit = d;
        @(posedge clk); #1;
        ifc.tlx_afu_resp_credit      = 1'b0;
        ifc.tlx_afu_resp_data_credit = 1'b0;
    endtask

    // Waits for the command credit that marks the response cycle.
    task automatic wait_resp(input logic give_back, input logic rv);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ifc.afu_tlx_cmd_credit) got = 1'b1;
        end
        check("resp_timeout", {511'b0, got}, 512'd1);
        if (give_back) pulse_credits(1'b1, rv);
    endtask

    task automatic txn(input logic [7:0] op, input logic [2:0] pl, input logic [63:0] pa,
                       input logic [63:0] wdata);
        logic rv;
        issue(op, pl, pa, wdata, rv);
        wait_resp(1'b1, rv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rv;
        logic got;
        int unsigned base;
        logic [7:0] op;
        logic [2:0] pl;

        ifc.tlx_afu_cmd_credit = 0; ifc.tlx_afu_cmd_data_credit = 0;
        ifc.tlx_afu_cmd_resp_initial_credit = 3'd4; ifc.tlx_afu_data_initial_credit = 5'd8;
        ifc.tlx_afu_resp_valid = 0; ifc.tlx_afu_resp_opcode = 0; ifc.tlx_afu_resp_afutag = 0;
        ifc.tlx_afu_resp_code = 0; ifc.tlx_afu_resp_dl = 0; ifc.tlx_afu_resp_dp = 0;
        ifc.tlx_afu_resp_pg_size = 0; ifc.tlx_afu_resp_addr_tag = 0;
        ifc.tlx_afu_resp_data_valid = 0; ifc.tlx_afu_resp_data_bdi = 0; ifc.tlx_afu_resp_data_bus = '0;
        ifc.tlx_afu_ready = 1; ifc.tlx_afu_cmd_valid = 0; ifc.tlx_afu_cmd_opcode = 0;
        ifc.tlx_afu_cmd_capptag = 0; ifc.tlx_afu_cmd_dl = 0; ifc.tlx_afu_cmd_pl = 0;
        ifc.tlx_afu_cmd_be = 0; ifc.tlx_afu_cmd_end = 0; ifc.tlx_afu_cmd_t = 0;
        ifc.tlx_afu_cmd_pa = 0; ifc.tlx_afu_cmd_flag = 0; ifc.tlx_afu_cmd_os = 0;
        ifc.tlx_afu_cmd_data_valid = 0; ifc.tlx_afu_cmd_data_bdi = 0; ifc.tlx_afu_cmd_data_bus = '0;
        ifc.tlx_afu_resp_credit = 0; ifc.tlx_afu_resp_data_credit = 0;
        ifc.afu_cfg_in_rcv_tmpl_capability_0 = 1; ifc.afu_cfg_in_rcv_tmpl_capability_1 = 1;
        ifc.afu_cfg_in_rcv_tmpl_capability_2 = 0; ifc.afu_cfg_in_rcv_tmpl_capability_3 = 1;
        ifc.afu_cfg_in_rcv_rate_capability_0 = 4'h3; ifc.afu_cfg_in_rcv_rate_capability_1 = 4'h5;
        ifc.afu_cfg_in_rcv_rate_capability_2 = 4'hA; ifc.afu_cfg_in_rcv_rate_capability_3 = 4'hF;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", {511'b0, ifc.afu_tlx_resp_valid}, '0);
        check("rst_cmd_credit", {511'b0, ifc.afu_tlx_cmd_credit}, '0);
        check("rst_cmd_rd_req", {511'b0, ifc.afu_tlx_cmd_rd_req}, '0);
        check("rst_resp_credit", {511'b0, ifc.afu_tlx_resp_credit}, '0);
        check_consts();

        // Directed cases
        txn(8'h28, 3'd3, 64'h0, 64'h0);
        txn(8'h86, 3'd3, 64'h18, 64'h0000_0000_DEAD_BEEF);
        txn(8'h28, 3'd3, 64'h18, 64'h0);
        txn(8'h20, 3'd3, 64'h18, 64'h0);
        txn(8'h81, 3'd3, 64'h40, 64'h1234);
        txn(8'h28, 3'd2, 64'h8, 64'h0);
        txn(8'h86, 3'd0, 64'h10, 64'h5555);
        txn(8'h86, 3'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        txn(8'h28, 3'd3, 64'h0, 64'h0);
        txn(8'h86, 3'd3, 64'h78, 64'hA5A5_0F0F_1234_5678);
        txn(8'h28, 3'd3, 64'h78, 64'h0);

        // Discarded TLX response returns one credit on the following cycle
        @(posedge clk); #1 ifc.tlx_afu_resp_valid = 1'b1; ifc.tlx_afu_resp_opcode = 8'h04;
        @(negedge clk);
        check("resp_credit_before", {511'b0, ifc.afu_tlx_resp_credit}, '0);
        @(posedge clk); #1 ifc.tlx_afu_resp_valid = 1'b0;
        @(negedge clk);
        check("resp_credit_pulse", {511'b0, ifc.afu_tlx_resp_credit}, 512'd1);
        @(negedge clk);
        check("resp_credit_after", {511'b0, ifc.afu_tlx_resp_credit}, '0);

        // Credit starvation: second read waits for both credits
        issue(8'h28, 3'd3, 64'h78, 64'h0, rv);
        wait_resp(1'b0, rv);
        issue(8'h28, 3'd3, 64'h18, 64'h0, rv);
        base = n_resp;
        repeat (12) @(negedge clk);
        check("stall_no_credit", 512'(n_resp), 512'(base));
        pulse_credits(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("stall_no_data_credit", 512'(n_resp), 512'(base));
        pulse_credits(1'b0, 1'b1);
        wait_resp(1'b1, 1'b1);
        check("stall_released", 512'(n_resp), 512'(base + 1));

        // Reset while waiting for write data abandons the command
        @(posedge clk); #1;
        ifc.tlx_afu_cmd_valid = 1'b1; ifc.tlx_afu_cmd_opcode = 8'h86;
        ifc.tlx_afu_cmd_pl = 3'd3; ifc.tlx_afu_cmd_pa = 64'h28;
        @(posedge clk); #1 ifc.tlx_afu_cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ifc.afu_tlx_cmd_rd_req) got = 1'b1;
        end
        check("dwait_rd_req_seen", {511'b0, got}, 512'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        base = n_resp;
        repeat (10) @(negedge clk);
        check("reset_no_resp", 512'(n_resp), 512'(base));
        txn(8'h28, 3'd3, 64'h18, 64'h0);
        txn(8'h28, 3'd3, 64'h78, 64'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0, 5:    op = 8'h28;
                1, 2:    op = 8'h86;
                3:       op = 8'h81;
                default: op = 8'($urandom);
            endcase
            pl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd3;
            txn(op, pl, {$urandom, $urandom}, {$urandom, $urandom});
        end
        check_consts();

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 512'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mcp3_afu_top.md
MCP3_AFU_TOP -- requirements
Module: mcp3_afu_top

Interface
REQ-001 The block SHALL have one clock and one reset:
  - clock_afu  in  1  sole clock; all logic on its rising edge.
  - clock_tlx  in  1  same net as clock_afu; no logic on it.
  - reset  in  1  synchronous, active-high.
REQ-002 AFU->TLX command outputs SHALL be: afu_tlx_cmd_valid 1, _opcode 8, _actag 12, _stream_id 4, _ea_or_obj 68, _afutag 16, _dl 2, _pl 3, _os 1, _be 64, _flag 4, _endian 1, _bdf 16, _pasid 20, _pg_size 6; afu_tlx_cdata_valid 1, _bdi 1, _bus 512.
REQ-003 TLX->AFU credit inputs SHALL be: tlx_afu_cmd_credit 1, tlx_afu_cmd_data_credit 1, tlx_afu_cmd_resp_initial_credit 3, tlx_afu_data_initial_credit 5.
REQ-004 TLX->AFU response inputs SHALL be: tlx_afu_resp_valid 1, _opcode 8, _afutag 16, _code 4, _dl 2, _dp 2, _pg_size 6, _addr_tag 18; tlx_afu_resp_data_valid 1, _bdi 1, _bus 512.
REQ-005 Response-side outputs SHALL be: afu_tlx_resp_rd_req 1, afu_tlx_resp_rd_cnt 3, afu_tlx_resp_credit 1, afu_tlx_resp_initial_credit 7.
REQ-006 Host-command inputs SHALL be: tlx_afu_ready 1; tlx_afu_cmd_valid 1, _opcode 8, _capptag 16, _dl 2, _pl 3, _be 64, _end 1, _t 1, _pa 64, _flag 4, _os 1; tlx_afu_cmd_data_valid 1, _bdi 1, _bus 512.
REQ-007 Host-command outputs SHALL be: afu_tlx_cmd_rd_req 1, afu_tlx_cmd_rd_cnt 3, afu_tlx_cmd_credit 1, afu_tlx_cmd_initial_credit 7.
REQ-008 Response-transmit outputs SHALL be: afu_tlx_resp_valid 1, _opcode 8, _dl 2, _capptag 16, _dp 2, _code 4; afu_tlx_rdata_valid 1, _bdi 1, _bus 512. Inputs: tlx_afu_resp_credit 1, tlx_afu_resp_data_credit 1.
REQ-009 Config ports SHALL be: inputs afu_cfg_in_rcv_tmpl_capability_0..3 (1 each), afu_cfg_in_rcv_rate_capability_0..3 (4 each); outputs afu_cfg_xmit_tmpl_config_0..3 (1), afu_cfg_xmit_rate_config_0..3 (4).

Function
REQ-010 The block SHALL never issue AFU commands: all afu_tlx_cmd_* and afu_tlx_cdata_* outputs constant 0.
REQ-011 Constants: afu_tlx_cmd_initial_credit=7'd1, afu_tlx_resp_initial_credit=7'd1, afu_tlx_resp_rd_req=0, afu_tlx_resp_rd_cnt=0, xmit_tmpl_config_0=1, tmpl_config_1..3=0, all xmit_rate_config=4'h0, afu_tlx_rdata_bdi=0.
REQ-012 afu_tlx_resp_credit SHALL pulse high one cycle after every cycle with tlx_afu_resp_valid=1; response content is discarded.
REQ-013 Register file: 16 x 64-bit registers, index pa[6:3]; reg 0 read-only, value 64'h0000_0000_4D43_5033; regs 1-15 read/write.
REQ-014 FSM states: IDLE, DREQ, DWAIT, RESP. Commands are accepted only in IDLE with tlx_afu_ready=1 and tlx_afu_cmd_valid=1; opcode, capptag, pl and pa are latched.
REQ-015 Write opcodes (0x86 pr_wr_mem, 0x81 write_mem): IDLE->DREQ; DREQ drives afu_tlx_cmd_rd_req=1, rd_cnt=3'b001 for one cycle, ->DWAIT; on tlx_afu_cmd_data_valid ->RESP.
REQ-016 All other opcodes SHALL go IDLE->RESP.
REQ-017 Valid access: opcode 0x28 or 0x86, pl=3'b011. A valid write stores lane pa[5:3] of tlx_afu_cmd_data_bus (bits 64*lane+63:64*lane) into the register unless index is 0 (then dropped, still success).
REQ-018 RESP waits until the resp-credit count >0 and, for reads, data-credit count >0. It then drives afu_tlx_resp_valid for one cycle with capptag echoed, dl=2'b01, dp=0 and:
  - valid read: opcode 0x01, code 0; rdata_valid=1, register in lane pa[5:3], other lanes 0.
  - valid write: opcode 0x04, code 0.
  - invalid read class (not 0x86/0x81): 0x02, code 4'hE.
  - invalid write class: 0x05, code 4'hE.
REQ-019 On the response cycle: afu_tlx_cmd_credit pulses 1, FSM returns to IDLE.
REQ-020 Credit counters (4-bit resp, 4-bit data): decrement on consumption, increment on tlx_afu_resp_credit / tlx_afu_resp_data_credit, saturate at 15; simultaneous increment and decrement leaves the count unchanged.

Reset
REQ-021 Reset SHALL put the FSM in IDLE, regs 1-15 to 0, resp and data credit counters to 1, and all pulse/valid outputs to 0; reset mid-command abandons it with no response.

Verification
REQ-022 pr_rd_mem pa=0, pl=3 -> resp 0x01, code 0, rdata lane 0 = 64'h4D435033.
REQ-023 pr_wr_mem pa=0x18, lane 3 = 64'hDEADBEEF -> cmd_rd_req/rd_cnt=1, resp 0x04; then pr_rd_mem pa=0x18 -> lane 3 = 64'hDEADBEEF, other lanes 0.
REQ-024 rd_mem 0x20 -> resp 0x02, code 0xE, no rdata_valid; afu_tlx_cmd_credit pulses.
REQ-025 Credits drained (one read sent, no tlx_afu_resp_credit) -> second read stalls in RESP until tlx_afu_resp_credit and tlx_afu_resp_data_credit arrive, then responds.
REQ-026 tlx_afu_resp_valid pulse -> afu_tlx_resp_credit high the next cycle; reset asserted while in DWAIT -> IDLE, no response emitted.
